// File: rtl/ppu_fb_writer.sv
// ppu_fb_writer: packs 2-bit PPU pixels 4 per byte, queues them and writes the frame buffer.
// Optional PPU_PALETTE_EN maps each pixel through bgp before packing.
module ppu_fb_writer #(
  parameter int H_PIXELS   = 160,
  parameter int V_LINES    = 144,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lcd_en,
  input  logic [1:0]        ppu_mode,
  input  logic [1:0]        px_in,
  input  logic              px_valid,
  input  logic [7:0]        bgp,
  output logic              fb_wr_req,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [7:0]        fb_wr_data,
  input  logic              fb_wr_ack,
  output logic              frame_done,
  output logic              overflow,
  output logic              extra_px
);
  localparam int XW = $clog2(H_PIXELS);
  localparam int YW = $clog2(V_LINES);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {ACTIVE, FLUSH, VBLANK} state_e;
  state_e            state_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [5:0]        pack_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] bcnt_q;
  logic              done_q, frame_done_q, overflow_q, extra_q;
  logic [PW:0]       wp_q, rp_q;
  logic [ADDR_W+7:0] mem_q [FIFO_DEPTH];
  logic [1:0]        pix;
  logic [7:0]        pack_d, data_d;
  logic [2:0]        cnt_d;
  logic              take, extra, vb_entry, push, empty, full, pop, wr;
`ifdef PPU_PALETTE_EN
  assign pix = px_in == 2'd3 ? bgp[7:6] : px_in == 2'd2 ? bgp[5:4] :
               px_in == 2'd1 ? bgp[3:2] : bgp[1:0];
`else
  logic unused_bgp;
  assign unused_bgp = ^bgp;
  assign pix = px_in;
`endif
  always_comb begin
    take     = lcd_en && px_valid && state_q == ACTIVE && !done_q;
    extra    = lcd_en && px_valid && (state_q == FLUSH || (state_q == ACTIVE && done_q));
    vb_entry = lcd_en && state_q == ACTIVE && ppu_mode == 2'd1;
    pack_d   = take ? {pack_q, pix} : {2'b00, pack_q};
    cnt_d    = {1'b0, cnt_q} + {2'b00, take};
    // left-justify so the first pixel lands in [7:6]; a partial byte is zero-padded
    data_d   = pack_d << {3'd4 - cnt_d, 1'b0};
    push     = (take && cnt_q == 2'd3) || (vb_entry && cnt_d != 3'd0);
    empty    = wp_q == rp_q;
    full     = (wp_q ^ rp_q) == {1'b1, {PW{1'b0}}};
    pop      = lcd_en && !empty && fb_wr_ack;
    wr       = push && (!full || pop);
  end
  assign fb_wr_req                = lcd_en && !empty;
  assign {fb_wr_addr, fb_wr_data} = fb_wr_req ? mem_q[rp_q[PW-1:0]] : '0;
  assign frame_done               = frame_done_q;
  assign overflow                 = overflow_q;
  assign extra_px                 = extra_q;
  always_ff @(posedge clk)
    if (wr) mem_q[wp_q[PW-1:0]] <= {bcnt_q, data_d};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ACTIVE;
      x_q          <= '0;
      y_q          <= '0;
      pack_q       <= '0;
      cnt_q        <= '0;
      bcnt_q       <= '0;
      done_q       <= 1'b0;
      wp_q         <= '0;
      rp_q         <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      extra_q      <= 1'b0;
    end else if (!lcd_en) begin
      state_q      <= ACTIVE;
      x_q          <= '0;
      y_q          <= '0;
      pack_q       <= '0;
      cnt_q        <= '0;
      bcnt_q       <= '0;
      done_q       <= 1'b0;
      wp_q         <= '0;
      rp_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (pop) rp_q <= rp_q + 1'b1;
      if (wr) wp_q <= wp_q + 1'b1;
      // dropped bytes still advance the address so later bytes stay raster-aligned
      if (push) bcnt_q <= bcnt_q + 1'b1;
      if (push && full && !pop) overflow_q <= 1'b1;
      if (extra) extra_q <= 1'b1;
      if (take) pack_q <= pack_d[5:0];
      cnt_q <= (push || vb_entry) ? 2'd0 : cnt_d[1:0];
      if (take) begin
        x_q <= (x_q == XW'(H_PIXELS - 1)) ? '0 : x_q + 1'b1;
        if (x_q == XW'(H_PIXELS - 1)) begin
          y_q    <= (y_q == YW'(V_LINES - 1)) ? y_q : y_q + 1'b1;
          done_q <= y_q == YW'(V_LINES - 1);
        end
      end
      if (state_q == ACTIVE && ppu_mode == 2'd1) state_q <= FLUSH;
      else if (state_q == FLUSH && empty) begin
        frame_done_q <= 1'b1;
        state_q      <= VBLANK;
      end else if (state_q == VBLANK && ppu_mode != 2'd1) begin
        state_q <= ACTIVE;
        x_q     <= '0;
        y_q     <= '0;
        bcnt_q  <= '0;
        done_q  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ppu_fb_writer.sv
// tb_ppu_fb_writer: directed and random stimulus checked against a pixel-level frame model.
module tb_ppu_fb_writer;
  localparam int H = 160, V = 144, D = 8, AW = 13;
  logic clk = 0, rst = 0, lcd_en = 0, px_valid = 0, fb_wr_ack = 0;
  logic [1:0] ppu_mode = 2'd3, px_in = 0;
  logic [7:0] bgp = 8'hE4;
  logic fb_wr_req, frame_done, overflow, extra_px;
  logic [AW-1:0] fb_wr_addr;
  logic [7:0] fb_wr_data;
  int checks = 0, errors = 0;
  int ph, npx, nfd;
  logic [1:0] pk[$];
  logic [20:0] fq[$];
  logic [20:0] wlog[$];
  logic e_done, e_ovf, e_extra;

  ppu_fb_writer dut (
    .clk(clk), .rst(rst), .lcd_en(lcd_en), .ppu_mode(ppu_mode), .px_in(px_in),
    .px_valid(px_valid), .bgp(bgp), .fb_wr_req(fb_wr_req), .fb_wr_addr(fb_wr_addr),
    .fb_wr_data(fb_wr_data), .fb_wr_ack(fb_wr_ack), .frame_done(frame_done),
    .overflow(overflow), .extra_px(extra_px)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] shade(logic [1:0] p);
`ifdef PPU_PALETTE_EN
    return bgp[2*p+1 -: 2];
`else
    return p;
`endif
  endfunction

  task automatic model_clear();
    ph = 0; npx = 0; pk.delete(); fq.delete(); e_done = 0; e_ovf = 0; e_extra = 0;
  endtask

  task automatic compare();
    logic exp_req;
    exp_req = lcd_en && fq.size() > 0;
    check("req", fb_wr_req, exp_req);
    if (exp_req) begin
      check("addr", fb_wr_addr, fq[0][20:8]);
      check("data", fb_wr_data, fq[0][7:0]);
    end
    check("frame_done", frame_done, e_done);
    check("overflow", overflow, e_ovf);
    check("extra_px", extra_px, e_extra);
  endtask

  // effect of the upcoming clock edge, from pixel positions rather than byte counters
  task automatic model_step();
    bit pop, fe;
    int first;
    logic [7:0] b;
    if (!lcd_en) begin
      ph = 0; npx = 0; pk.delete(); fq.delete(); e_done = 0;
      return;
    end
    e_done = 0;
    fe = fq.size() == 0;
    pop = fq.size() > 0 && fb_wr_ack;
    if (px_valid && (ph == 1 || (ph == 0 && npx == H*V))) e_extra = 1;
    if (px_valid && ph == 0 && npx < H*V) begin
      pk.push_back(shade(px_in));
      npx++;
    end
    if (pop) void'(fq.pop_front());
    if (pk.size() == 4 || (ph == 0 && ppu_mode == 2'd1 && pk.size() > 0)) begin
      b = 0;
      for (int i = 0; i < 4; i++) b = {b[5:0], (i < pk.size()) ? pk[i] : 2'b00};
      first = (npx - pk.size()) / 4;
      if (fq.size() < D) fq.push_back({13'(first), b});
      else e_ovf = 1;
      pk.delete();
    end
    if (ph == 0 && ppu_mode == 2'd1) ph = 1;
    else if (ph == 1 && fe) begin e_done = 1; ph = 2; end
    else if (ph == 2 && ppu_mode != 2'd1) begin ph = 0; npx = 0; end
  endtask

  task automatic cyc(bit l, bit [1:0] m, bit v, bit [1:0] p, bit a);
    @(negedge clk);
    lcd_en = l; ppu_mode = m; px_valid = v; px_in = p; fb_wr_ack = a;
    #1;
    compare();
    if (fb_wr_req && fb_wr_ack) wlog.push_back({fb_wr_addr, fb_wr_data});
    if (frame_done) nfd++;
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 rst = 0; lcd_en = 0; px_valid = 0; fb_wr_ack = 0;
    #1;
    check("rst_req", fb_wr_req, 0);
    check("rst_addr", fb_wr_addr, 0);
    check("rst_data", fb_wr_data, 0);
    check("rst_done", frame_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_extra", extra_px, 0);
    model_clear();
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    int vb_left, stall_left;
    model_clear();
    #2;
    check("init_req", fb_wr_req, 0);
    check("init_ovf", overflow, 0);
    check("init_extra", extra_px, 0);
    check("init_done", frame_done, 0);
    @(negedge clk);
    rst = 1;
    // full frame of 2'b01 with ack tied high
    wlog.delete(); nfd = 0;
    for (int i = 0; i < H*V; i++) cyc(1, 3, 1, 1, 1);
    cyc(1, 3, 1, 2, 1);
    cyc(1, 3, 0, 0, 1);
    check("t1_extra", extra_px, 1);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 1);
    check("t1_writes", wlog.size(), H*V/4);
    check("t1_last", wlog[wlog.size()-1], {13'(H*V/4 - 1), 8'h55});
    check("t1_frame_done", nfd, 1);
    check("t1_ovf", overflow, 0);
    // line 0 pixels 3,2,1,0 then line 1 pixel 0
    cyc(1, 3, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 3, 1, 2'(3 - i), 0);
    cyc(1, 3, 0, 0, 0);
    check("t2_req", fb_wr_req, 1);
    check("t2_addr", fb_wr_addr, 0);
    check("t2_data", fb_wr_data, 8'hE4);
    for (int i = 4; i < H + 4; i++) cyc(1, 3, 1, 2'($urandom), 1);
    cyc(1, 3, 0, 0, 1);
    cyc(1, 3, 0, 0, 1);
    check("t2_line1_addr", wlog[wlog.size()-1][20:8], H/4);
    // async reset with a byte waiting and sticky extra_px set
    for (int i = 0; i < 4; i++) cyc(1, 3, 1, 1, 0);
    do_reset();
    // 12 bytes with ack held low
    for (int i = 0; i < 48; i++) cyc(1, 3, 1, 2'($urandom), 0);
    cyc(1, 3, 0, 0, 0);
    check("t3_ovf", overflow, 1);
    wlog.delete();
    for (int i = 0; i < 12; i++) cyc(1, 3, 0, 0, 1);
    check("t3_writes", wlog.size(), 8);
    check("t3_addr7", wlog[wlog.size()-1][20:8], 7);
    for (int i = 0; i < 4; i++) cyc(1, 3, 1, 2'($urandom), 1);
    cyc(1, 3, 0, 0, 1);
    cyc(1, 3, 0, 0, 1);
    check("t3_addr12", wlog[wlog.size()-1][20:8], 12);
    // 6 pixels then V-blank pads the second byte
    do_reset();
    wlog.delete(); nfd = 0;
    for (int i = 0; i < 6; i++) cyc(1, 3, 1, 3, 1);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 1);
    check("t4_writes", wlog.size(), 2);
    check("t4_w0", wlog[0], {13'd0, 8'hFF});
    check("t4_w1", wlog[wlog.size()-1], {13'd1, 8'hF0});
    check("t4_frame_done", nfd, 1);
    // LCD off with 3 bytes queued
    cyc(1, 3, 0, 0, 0);
    for (int i = 0; i < 14; i++) cyc(1, 3, 1, 2, 0);
    wlog.delete(); nfd = 0;
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 1);
    check("t5_writes_off", wlog.size(), 0);
    for (int i = 0; i < 4; i++) cyc(1, 3, 1, 1, 1);
    cyc(1, 3, 0, 0, 1);
    cyc(1, 3, 0, 0, 1);
    check("t5_frame_done", nfd, 0);
    check("t5_addr", wlog[0][20:8], 0);
    // palette
    do_reset();
    wlog.delete();
    bgp = 8'hE4;
    for (int i = 0; i < 4; i++) cyc(1, 3, 1, 0, 1);
    bgp = 8'h1B;
    for (int i = 0; i < 4; i++) cyc(1, 3, 1, 0, 1);
    cyc(1, 3, 0, 0, 1);
    cyc(1, 3, 0, 0, 1);
    check("t6_e4", wlog[0][7:0], 8'h00);
`ifdef PPU_PALETTE_EN
    check("t6_1b", wlog[wlog.size()-1][7:0], 8'hFF);
`else
    check("t6_1b", wlog[wlog.size()-1][7:0], 8'h00);
`endif
    // random traffic: early V-blanks, stalls, LCD off, palette changes
    do_reset();
    vb_left = 0; stall_left = 0;
    for (int i = 0; i < 20000; i++) begin
      if (i % 2000 == 0) bgp = 8'($urandom);
      if (vb_left > 0) vb_left--;
      else if ($urandom_range(0, 299) == 0) vb_left = $urandom_range(3, 40);
      if (stall_left > 0) stall_left--;
      else if ($urandom_range(0, 149) == 0) stall_left = $urandom_range(5, 60);
      cyc($urandom_range(0, 399) != 0, vb_left > 0 ? 2'd1 : 2'($urandom_range(2, 3)) ^ 2'd0,
          $urandom_range(0, 3) != 0, 2'($urandom), stall_left == 0 && $urandom_range(0, 2) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
